// File: rtl/reg_wb_buffer_pkg.sv
// Shared types and constants for the register-file writeback buffer.
package reg_wb_buffer_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned AW       = 5;
  localparam int unsigned WB_DEPTH = 4;

  localparam logic [AW-1:0] REG_X0 = 5'd0;

  // One queued register write.
  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // True when a pending entry targets a real (non-x0) register matching addr.
  function automatic logic entryMatches(input wb_entry_t entry, input logic [AW-1:0] addr);
    return (addr != REG_X0) && (entry.rd == addr);
  endfunction

endpackage

// File: rtl/reg_wb_buffer_fifo.sv
// In-order storage for pending register writes: array, pointers and occupancy.
module wb_fifo
  import reg_wb_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = WB_DEPTH,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             pushEntry,
  input  logic                  pop,
  output wb_entry_t [DEPTH-1:0] entries,
  output logic      [PW-1:0]    rdPtr,
  output logic      [CW-1:0]    count
);

  wb_entry_t [DEPTH-1:0] mem;
  logic      [PW-1:0]    wrPtr;

  assign entries = mem;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only occupied slots are ever observed.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wrPtr] <= pushEntry;
  end

endmodule

// File: rtl/reg_wb_buffer.sv
// Writeback buffer feeding the register file write port, with pending-write lookup.
// Build option: REG_WB_BUFFER_FWD_EN enables the forwarding comparators.
module reg_wb_buffer
  import reg_wb_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = WB_DEPTH,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rd,
  input  logic [XLEN-1:0] in_data,
  input  logic            hold,
  output logic            write_en,
  output logic [AW-1:0]   RW,
  output logic [XLEN-1:0] busW,
  input  logic [AW-1:0]   RA,
  input  logic [AW-1:0]   RB,
  output logic            fwd_a_hit,
  output logic [XLEN-1:0] fwd_a_data,
  output logic            fwd_b_hit,
  output logic [XLEN-1:0] fwd_b_data,
  output logic [CW-1:0]   count
);

  wb_entry_t [DEPTH-1:0] entries;
  wb_entry_t             headEntry;
  wb_entry_t             pushEntry;
  logic      [PW-1:0]    rdPtr;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  notEmpty;

  // No pass-through when full: a same-cycle pop does not free a slot.
  assign in_ready  = (count < CW'(DEPTH)) && !rst;
  assign accept    = in_valid && in_ready;
  assign push      = accept && (in_rd != REG_X0);
  assign notEmpty  = (count != '0);
  assign write_en  = notEmpty && !hold && !rst;
  assign pop       = write_en;
  assign pushEntry = '{rd: in_rd, data: in_data};
  assign headEntry = entries[rdPtr];
  assign RW        = notEmpty ? headEntry.rd   : '0;
  assign busW      = notEmpty ? headEntry.data : '0;

  wb_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushEntry(pushEntry),
    .pop      (pop),
    .entries  (entries),
    .rdPtr    (rdPtr),
    .count    (count)
  );

`ifdef REG_WB_BUFFER_FWD_EN
  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_a_hit  = 1'b0;
    fwd_a_data = '0;
    fwd_b_hit  = 1'b0;
    fwd_b_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if (entryMatches(entries[rdPtr + PW'(i)], RA)) begin
          fwd_a_hit  = 1'b1;
          fwd_a_data = entries[rdPtr + PW'(i)].data;
        end
        if (entryMatches(entries[rdPtr + PW'(i)], RB)) begin
          fwd_b_hit  = 1'b1;
          fwd_b_data = entries[rdPtr + PW'(i)].data;
        end
      end
    end
  end
`else
  logic unusedFwd;
  assign unusedFwd  = ^{RA, RB};
  assign fwd_a_hit  = 1'b0;
  assign fwd_a_data = '0;
  assign fwd_b_hit  = 1'b0;
  assign fwd_b_data = '0;
`endif

endmodule
